// File: rtl/addsub_pkg.sv
// Shared FSM encoding and op-code constants for the digit-serial
// adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational D-bit ripple adder slice; also exposes the carry
// into its top bit so the caller can derive signed overflow.
module addsub_digit #(
    parameter int D = 2
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    input  logic         cin,
    output logic [D-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [D:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < D; i++) begin
            sum[i]   = x[i] ^ y[i] ^ w_c[i];
            w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout = w_c[D];
    assign cmsb = w_c[D-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: N-bit operands processed D bits per
// clock, LSB digit first, with a registered carry between digits.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         op_code,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic         c_out,
    output logic         ovf
);

    localparam int NDIG = N / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_acc;
    logic [N-1:0]   w_acc;
    logic           r_op;
    logic           r_cy;
    logic [CW-1:0]  r_cnt;
    logic [D-1:0]   w_x;
    logic [D-1:0]   w_bd;
    logic [D-1:0]   w_y;
    logic [D-1:0]   w_sum;
    logic           w_cout;
    logic           w_cmsb;
    logic           w_last;
    logic           w_accept;
    int             w_base;

    assign w_base   = int'(r_cnt) * D;
    assign w_x      = r_a[w_base +: D];
    assign w_bd     = r_b[w_base +: D];
    assign w_y      = (r_op == OP_SUB) ? ~w_bd : w_bd;
    assign w_last   = (r_cnt == LAST);
    assign w_accept = start && (r_state != S_RUN);

    addsub_digit #(.D(D)) u_digit (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_cy),
        .sum  (w_sum),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    always_comb begin
        w_acc = r_acc;
        w_acc[w_base +: D] = w_sum;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Subtract enters as a + ~b + (1 - c_in): seed carry with c_in ^ op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_op  <= 1'b0;
            r_cy  <= 1'b0;
            r_cnt <= '0;
            q     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op_code;
            r_cy  <= c_in ^ op_code;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc;
            r_cy  <= w_cout;
            if (w_last) begin
                q     <= w_acc;
                c_out <= w_cout;
                ovf   <= w_cmsb ^ w_cout;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised and directed bench for serial_addsub (N=8/D=2 and N=4/D=1)
// against an integer-arithmetic reference model.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, c_in, op_code;
    logic [7:0] a, b, q;
    logic       busy, done, c_out, ovf;

    logic       t_start, t_cin, t_op;
    logic [3:0] t_a, t_b, t_q;
    logic       t_busy, t_done, t_cout, t_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_addsub #(.N(8), .D(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .c_in(c_in), .op_code(op_code), .busy(busy), .done(done),
        .q(q), .c_out(c_out), .ovf(ovf)
    );

    serial_addsub #(.N(4), .D(1)) dut4 (
        .clk(clk), .rst(rst), .start(t_start), .a(t_a), .b(t_b),
        .c_in(t_cin), .op_code(t_op), .busy(t_busy), .done(t_done),
        .q(t_q), .c_out(t_cout), .ovf(t_ovf)
    );

    function automatic void model(input int n, input int ia, input int ib,
                                  input int ic, input int io,
                                  output int mq, output int mc, output int mv);
        int m, s, sa, sb, r;
        m  = 1 << n;
        sa = (ia >= m / 2) ? ia - m : ia;
        sb = (ib >= m / 2) ? ib - m : ib;
        if (io == 0) begin
            s  = ia + ib + ic;
            mc = (s >= m) ? 1 : 0;
            r  = sa + sb + ic;
        end else begin
            s  = ia - ib - ic;
            mc = (s >= 0) ? 1 : 0;
            r  = sa - sb - ic;
        end
        mq = (s + m) % m;
        mv = (r < -(m / 2) || r > m / 2 - 1) ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int ia, input int ib, input int ic, input int io,
                         output int lat, output int bcnt);
        a       = ia[7:0];
        b       = ib[7:0];
        c_in    = ic[0];
        op_code = io[0];
        start   = 1'b1;
        step();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        step();
        step();
        total++;
        if ({busy, done, q, c_out, ovf} !== 11'b0) begin
            bad++;
            $display("FAIL reset outs=%b want 0", {busy, done, q, c_out, ovf});
        end
        total++;
        if ({t_busy, t_done, t_q, t_cout, t_ovf} !== 7'b0) begin
            bad++;
            $display("FAIL reset4 outs=%b want 0", {t_busy, t_done, t_q, t_cout, t_ovf});
        end
        start = 1'b0;
        rst   = 1'b0;
        step();
    endtask

    task automatic test_directed();
        int ta[5] = '{100, 200, 127, 5, 9};
        int tb[5] = '{27, 100, 1, 7, 4};
        int tc[5] = '{0, 1, 0, 0, 1};
        int tp[5] = '{0, 0, 0, 1, 1};
        int tq[5] = '{127, 45, 128, 254, 4};
        int lat, bc, mq, mc, mv, held;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], tc[i], tp[i], lat, bc);
            model(8, ta[i], tb[i], tc[i], tp[i], mq, mc, mv);
            total++;
            if (lat != 4 || bc != 4 || busy !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_lat lat=%0d busy_cycles=%0d want 4/4", i, lat, bc);
            end
            total++;
            if (int'(q) !== tq[i] || int'(q) !== mq) begin
                bad++;
                $display("FAIL dir%0d_q q=%0d want %0d", i, q, tq[i]);
            end
            total++;
            if (int'(c_out) !== mc || int'(ovf) !== mv) begin
                bad++;
                $display("FAIL dir%0d_flags c=%0d v=%0d want %0d %0d", i, c_out, ovf, mc, mv);
            end
            held = int'(q);
            a = ~a;
            step();
            total++;
            if (done !== 1'b0 || int'(q) !== held) begin
                bad++;
                $display("FAIL dir%0d_hold done=%0d q=%0d want 0 %0d", i, done, q, held);
            end
        end
    endtask

    task automatic test_ignore_start();
        int bc = 0, dc = 0, mq, mc, mv;
        model(8, 57, 99, 1, 0, mq, mc, mv);
        a = 8'd57; b = 8'd99; c_in = 1'b1; op_code = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (busy) bc++;
            if (done) dc++;
            if (i == 1) begin
                a = 8'd3; b = 8'd250; c_in = 1'b0; op_code = 1'b1; start = 1'b1;
            end
            if (i == 2) start = 1'b0;
            step();
        end
        total++;
        if (bc != 4 || dc != 1) begin
            bad++;
            $display("FAIL ignore_cnt busy=%0d done=%0d want 4 1", bc, dc);
        end
        total++;
        if (int'(q) !== mq || int'(c_out) !== mc || int'(ovf) !== mv) begin
            bad++;
            $display("FAIL ignore_res q=%0d c=%0d want %0d %0d", q, c_out, mq, mc);
        end
    endtask

    task automatic test_reset_mid_run();
        int dc = 0, lat, bc, mq, mc, mv;
        a = 8'd240; b = 8'd33; c_in = 1'b0; op_code = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) dc++;
            if (i == 2) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        total++;
        if ({busy, done, q, c_out, ovf} !== 11'b0) begin
            bad++;
            $display("FAIL midrst_outs outs=%b want 0", {busy, done, q, c_out, ovf});
        end
        for (int i = 0; i < 5; i++) begin
            if (done) dc++;
            step();
        end
        total++;
        if (dc != 0) begin
            bad++;
            $display("FAIL midrst_done pulses=%0d want 0", dc);
        end
        do_op(77, 200, 1, 1, lat, bc);
        model(8, 77, 200, 1, 1, mq, mc, mv);
        total++;
        if (lat != 4 || int'(q) !== mq || int'(c_out) !== mc || int'(ovf) !== mv) begin
            bad++;
            $display("FAIL midrst_after lat=%0d q=%0d c=%0d v=%0d want 4 %0d %0d %0d",
                     lat, q, c_out, ovf, mq, mc, mv);
        end
        step();
    endtask

    task automatic test_random();
        int ia, ib, ic, io, lat, bc, mq, mc, mv;
        for (int i = 0; i < 40; i++) begin
            ia = int'($urandom_range(0, 255));
            ib = int'($urandom_range(0, 255));
            ic = int'($urandom_range(0, 1));
            io = int'($urandom_range(0, 1));
            do_op(ia, ib, ic, io, lat, bc);
            model(8, ia, ib, ic, io, mq, mc, mv);
            total++;
            if (lat != 4 || int'(q) !== mq || int'(c_out) !== mc || int'(ovf) !== mv) begin
                bad++;
                $display("FAIL rand%0d a=%0d b=%0d ci=%0d op=%0d got lat=%0d q=%0d c=%0d v=%0d want 4 %0d %0d %0d",
                         i, ia, ib, ic, io, lat, q, c_out, ovf, mq, mc, mv);
            end
            if ($urandom_range(0, 1) == 1) step();
        end
        step();
    endtask

    task automatic test_back_to_back();
        int ic, io, lat, mq, mc, mv;
        t_start = 1'b1;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                ic    = int'($urandom_range(0, 1));
                io    = int'($urandom_range(0, 1));
                t_a   = ia[3:0];
                t_b   = ib[3:0];
                t_cin = ic[0];
                t_op  = io[0];
                step();
                total++;
                if (t_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_busy a=%0d b=%0d busy=%0d want 1", ia, ib, t_busy);
                end
                t_a = ~t_a;
                t_b = ~t_b;
                lat = 0;
                while (!t_done && lat < 20) begin
                    step();
                    lat++;
                end
                model(4, ia, ib, ic, io, mq, mc, mv);
                total++;
                if (lat != 4 || t_busy !== 1'b0 || int'(t_q) !== mq ||
                    int'(t_cout) !== mc || int'(t_ovf) !== mv) begin
                    bad++;
                    $display("FAIL b2b a=%0d b=%0d ci=%0d op=%0d got lat=%0d q=%0d c=%0d v=%0d want 4 %0d %0d %0d",
                             ia, ib, ic, io, lat, t_q, t_cout, t_ovf, mq, mc, mv);
                end
            end
        end
        t_start = 1'b0;
        step();
        step();
        total++;
        if (t_busy !== 1'b0 || t_done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end busy=%0d done=%0d want 0 0", t_busy, t_done);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; op_code = 1'b0;
        t_start = 1'b0; t_a = '0; t_b = '0; t_cin = 1'b0; t_op = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
